// File: rtl/traffic_light_ctrl_if.sv
// Lamp/sensor bundle for the highway/farm-road intersection controller.
//   sensor        farm-road vehicle sensor (asynchronous to clk)
//   ped_req       pedestrian crossing request pulse
//   flash_en      level, 1 = flash mode
//   light_highway {R,Y,G} highway lamps
//   light_farm    {R,Y,G} farm-road lamps
//   ped_walk      walk lamp for the farm-road crossing
//   state_o       current state code (debug)
// master drives the requests and observes the lamps; slave is the controller.
interface traffic_light_ctrl_if;
   logic       sensor;
   logic       ped_req;
   logic       flash_en;
   logic [2:0] light_highway;
   logic [2:0] light_farm;
   logic       ped_walk;
   logic [2:0] state_o;

   modport master (
      output sensor, ped_req, flash_en,
      input  light_highway, light_farm, ped_walk, state_o
   );

   modport slave (
      input  sensor, ped_req, flash_en,
      output light_highway, light_farm, ped_walk, state_o
   );
endinterface

// File: rtl/traffic_light_ctrl.sv
// Highway/farm-road intersection controller with debounced farm sensor, bounded farm green,
// latched pedestrian request, all-red clearance and a flash (fault/maintenance) mode.
// All timing is in clk cycles.
//   clk   system clock, rising edge
//   rst_n asynchronous active-low reset
//   bus   traffic_light_ctrl_if.slave: sensor/ped_req/flash_en in, lamps/walk/state_o out
// Lamps, walk and state_o are registered and change on the same edge as the state.
module traffic_light_ctrl #(
   parameter int unsigned CNT_W          = 24,
   parameter int unsigned HWY_MIN_GREEN  = 30,
   parameter int unsigned FARM_MIN_GREEN = 10,
   parameter int unsigned FARM_MAX_GREEN = 20,
   parameter int unsigned YELLOW_TIME    = 3,
   parameter int unsigned ALL_RED_TIME   = 2,
   parameter int unsigned DEB_CYC        = 4,
   parameter int unsigned FLASH_HALF     = 500
) (
   input logic                 clk,
   input logic                 rst_n,
   traffic_light_ctrl_if.slave bus
);

   typedef enum logic [2:0] {
      StHwyG  = 3'd0,
      StHwyY  = 3'd1,
      StRedA  = 3'd2,
      StFarmG = 3'd3,
      StFarmY = 3'd4,
      StRedB  = 3'd5,
      StFlash = 3'd6
   } state_e;

   localparam int unsigned DebW = $clog2(DEB_CYC + 1);

   // Timer value on the last cycle of each interval ("hold D cycles" = exit at D-1).
   localparam logic [CNT_W-1:0] HwyMinLast  = CNT_W'(HWY_MIN_GREEN - 1);
   localparam logic [CNT_W-1:0] FarmMinLast = CNT_W'(FARM_MIN_GREEN - 1);
   localparam logic [CNT_W-1:0] FarmMaxLast = CNT_W'(FARM_MAX_GREEN - 1);
   localparam logic [CNT_W-1:0] YelLast     = CNT_W'(YELLOW_TIME - 1);
   localparam logic [CNT_W-1:0] RedLast     = CNT_W'(ALL_RED_TIME - 1);
   localparam logic [CNT_W-1:0] FlashLast   = CNT_W'(FLASH_HALF - 1);
   localparam logic [DebW-1:0]  DebLast     = DebW'(DEB_CYC - 1);

   localparam logic [2:0] LRed = 3'b100;
   localparam logic [2:0] LYel = 3'b010;
   localparam logic [2:0] LGrn = 3'b001;
   localparam logic [2:0] LOff = 3'b000;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] timer_q, timer_d;
   logic             sync1_q, sync2_q;
   logic             sensor_db_q, sensor_db_d;
   logic [DebW-1:0]  deb_cnt_q, deb_cnt_d;
   logic             ped_pend_q, ped_pend_d;
   logic             dark_q, dark_d;   // flash blink phase, 1 = lamps off
   logic [2:0]       hwy_q, hwy_d;
   logic [2:0]       farm_q, farm_d;
   logic             walk_q, walk_d;
   logic             enter_farm;

   // Debounce: count consecutive synced samples that disagree with the accepted value;
   // any agreeing sample restarts the count, so short glitches never get through.
   always_comb begin
      sensor_db_d = sensor_db_q;
      deb_cnt_d   = '0;
      if (sync2_q != sensor_db_q) begin
         if (deb_cnt_q == DebLast) begin
            sensor_db_d = sync2_q;
         end else begin
            deb_cnt_d = deb_cnt_q + DebW'(1);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StHwyG:  if (timer_q >= HwyMinLast && (sensor_db_q || ped_pend_q)) state_d = StHwyY;
         StHwyY:  if (timer_q == YelLast) state_d = StRedA;
         StRedA:  if (timer_q == RedLast) state_d = StFarmG;
         StFarmG: if (timer_q == FarmMaxLast || (timer_q >= FarmMinLast && !sensor_db_q))
                     state_d = StFarmY;
         StFarmY: if (timer_q == YelLast) state_d = StRedB;
         StRedB:  if (timer_q == RedLast) state_d = StHwyG;
         StFlash: state_d = StRedB;   // only taken when flash_en has dropped
         default: state_d = StHwyG;
      endcase
      if (bus.flash_en) state_d = StFlash;
   end

   assign enter_farm = (state_d == StFarmG) && (state_q != StFarmG);

   always_comb begin
      dark_d = dark_q;
      if (state_d != state_q) begin
         timer_d = '0;
         dark_d  = 1'b0;
      end else if (state_q == StFlash && timer_q == FlashLast) begin
         // Flash reuses the timer per half period so the blink never saturates.
         timer_d = '0;
         dark_d  = ~dark_q;
      end else if (timer_q != '1) begin
         timer_d = timer_q + CNT_W'(1);
      end else begin
         timer_d = timer_q;
      end

      // A request arriving on the entry edge is kept for the next farm phase.
      if (bus.ped_req) begin
         ped_pend_d = 1'b1;
      end else if (enter_farm) begin
         ped_pend_d = 1'b0;
      end else begin
         ped_pend_d = ped_pend_q;
      end

      walk_d = (state_d == StFarmG) && (enter_farm ? ped_pend_q : walk_q);

      hwy_d  = LRed;
      farm_d = LRed;
      case (state_d)
         StHwyG:  hwy_d  = LGrn;
         StHwyY:  hwy_d  = LYel;
         StFarmG: farm_d = LGrn;
         StFarmY: farm_d = LYel;
         StFlash: begin
            hwy_d  = dark_d ? LOff : LYel;
            farm_d = dark_d ? LOff : LRed;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StHwyG;
         timer_q     <= '0;
         sync1_q     <= 1'b0;
         sync2_q     <= 1'b0;
         sensor_db_q <= 1'b0;
         deb_cnt_q   <= '0;
         ped_pend_q  <= 1'b0;
         dark_q      <= 1'b0;
         hwy_q       <= LGrn;
         farm_q      <= LRed;
         walk_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         sync1_q     <= bus.sensor;
         sync2_q     <= sync1_q;
         sensor_db_q <= sensor_db_d;
         deb_cnt_q   <= deb_cnt_d;
         ped_pend_q  <= ped_pend_d;
         dark_q      <= dark_d;
         hwy_q       <= hwy_d;
         farm_q      <= farm_d;
         walk_q      <= walk_d;
      end
   end

   assign bus.light_highway = hwy_q;
   assign bus.light_farm    = farm_q;
   assign bus.ped_walk      = walk_q;
   assign bus.state_o       = state_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Bench for traffic_light_ctrl: a cycle-level reference model computed from the timing rules
// (durations, sensor history, pending request) is compared against the lamps every cycle,
// plus directed scenarios with hand-derived expected durations and patterns.
module tb_traffic_light_ctrl;
   localparam int unsigned HMG  = 8;
   localparam int unsigned FMIN = 4;
   localparam int unsigned FMAX = 10;
   localparam int unsigned YT   = 3;
   localparam int unsigned ART  = 2;
   localparam int unsigned DEB  = 2;
   localparam int unsigned FH   = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   traffic_light_ctrl_if bus ();

   traffic_light_ctrl #(
      .CNT_W(24), .HWY_MIN_GREEN(HMG), .FARM_MIN_GREEN(FMIN), .FARM_MAX_GREEN(FMAX),
      .YELLOW_TIME(YT), .ALL_RED_TIME(ART), .DEB_CYC(DEB), .FLASH_HALF(FH)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   always #5 clk = ~clk;

   int n_total = 0;
   int n_pass  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
   endtask

   // ---------------- reference model ----------------
   int m_ph;      // spec state code
   int m_cnt;     // completed cycles in the current state (unbounded)
   bit m_pend, m_walk, m_db;
   bit raw_hist[$];   // raw sensor samples, newest first

   task automatic model_reset();
      m_ph = 0; m_cnt = 0; m_pend = 0; m_walk = 0; m_db = 0;
      raw_hist = {};
      for (int i = 0; i < int'(DEB) + 2; i++) raw_hist.push_back(1'b0);
   endtask

   task automatic model_step(input bit s, input bit p, input bit f);
      int  dur, nxt;
      bit  stable, v, entering;
      raw_hist.push_front(s);
      // Samples two or more edges old have passed the synchroniser.
      v = raw_hist[2];
      stable = 1'b1;
      for (int i = 2; i < int'(DEB) + 2; i++) if (raw_hist[i] != v) stable = 1'b0;
      void'(raw_hist.pop_back());

      dur = m_cnt + 1;
      nxt = m_ph;
      if (f) nxt = 6;
      else begin
         case (m_ph)
            0: if (dur >= int'(HMG) && (m_db || m_pend)) nxt = 1;
            1: if (dur == int'(YT)) nxt = 2;
            2: if (dur == int'(ART)) nxt = 3;
            3: if (dur == int'(FMAX) || (dur >= int'(FMIN) && !m_db)) nxt = 4;
            4: if (dur == int'(YT)) nxt = 5;
            5: if (dur == int'(ART)) nxt = 0;
            default: nxt = 5;
         endcase
      end
      entering = (nxt == 3) && (m_ph != 3);
      if (entering) m_walk = m_pend;
      else if (nxt != 3) m_walk = 1'b0;
      if (p) m_pend = 1'b1;
      else if (entering) m_pend = 1'b0;
      m_cnt = (nxt != m_ph) ? 0 : m_cnt + 1;
      m_ph = nxt;
      if (stable) m_db = v;
   endtask

   function automatic logic [5:0] model_lamps();   // {hwy, farm}
      case (m_ph)
         0: return {3'b001, 3'b100};
         1: return {3'b010, 3'b100};
         3: return {3'b100, 3'b001};
         4: return {3'b100, 3'b010};
         6: return (((m_cnt / int'(FH)) % 2) == 0) ? {3'b010, 3'b100} : 6'b0;
         default: return {3'b100, 3'b100};
      endcase
   endfunction

   always @(posedge clk) if (rst_n) model_step(bus.sensor, bus.ped_req, bus.flash_en);

   always @(negedge clk) begin
      logic [5:0] exp_l;
      exp_l = model_lamps();
      check("hwy", bus.light_highway, exp_l[5:3]);
      check("farm", bus.light_farm, exp_l[2:0]);
      check("walk", bus.ped_walk, m_walk);
      check("state", bus.state_o, m_ph);
      if (bus.state_o != 3'd6) begin
         assert (bus.light_highway == 3'b100 || bus.light_farm == 3'b100);
         check("safety_one_red", (bus.light_highway == 3'b100 || bus.light_farm == 3'b100), 1);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic drive(input bit s, input bit p, input bit f);
      @(negedge clk);
      #1;
      bus.sensor = s; bus.ped_req = p; bus.flash_en = f;
   endtask

   task automatic do_reset(input bit s);
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      model_reset();
      bus.sensor = 1'b0; bus.ped_req = 1'b0; bus.flash_en = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      bus.sensor = s;
      rst_n = 1'b1;
   endtask

   task automatic wait_state(input string tag, input int code, input int limit, input bit s);
      int n = 0;
      while (bus.state_o != code && n < limit) begin
         drive(s, 1'b0, 1'b0);
         n++;
      end
      check(tag, bus.state_o, code);
   endtask

   int st_log[40];
   int run_st[40];
   int run_len[40];

   initial begin
      int nr, n, s_run, s_val, f_run;
      model_reset();
      bus.sensor = 1'b0; bus.ped_req = 1'b0; bus.flash_en = 1'b0;

      // Idle highway green with no demand, then a one-cycle sensor glitch.
      do_reset(1'b0);
      check("reset_hwy", bus.light_highway, 3'b001);
      check("reset_farm", bus.light_farm, 3'b100);
      check("reset_state", bus.state_o, 0);
      repeat (200) drive(1'b0, 1'b0, 1'b0);
      check("idle_state", bus.state_o, 0);
      drive(1'b1, 1'b0, 1'b0);
      repeat (30) drive(1'b0, 1'b0, 1'b0);
      check("glitch_state", bus.state_o, 0);

      // Sensor held high from reset release: measure every phase length.
      do_reset(1'b1);
      st_log[0] = int'(bus.state_o);
      for (int i = 1; i < 40; i++) begin
         @(negedge clk);
         #1;
         st_log[i] = int'(bus.state_o);
      end
      for (int i = 0; i < 40; i++) begin run_st[i] = -1; run_len[i] = 0; end
      nr = 0;
      run_st[0] = st_log[0];
      for (int i = 0; i < 40; i++) begin
         if (st_log[i] != run_st[nr]) begin nr++; run_st[nr] = st_log[i]; end
         run_len[nr]++;
      end
      check("seq0_st", run_st[0], 0); check("seq0_len", run_len[0], HMG);
      check("seq1_st", run_st[1], 1); check("seq1_len", run_len[1], YT);
      check("seq2_st", run_st[2], 2); check("seq2_len", run_len[2], ART);
      check("seq3_st", run_st[3], 3); check("seq3_len", run_len[3], FMAX);
      check("seq4_st", run_st[4], 4); check("seq4_len", run_len[4], YT);
      check("seq5_st", run_st[5], 5); check("seq5_len", run_len[5], ART);
      check("seq6_st", run_st[6], 0); check("seq6_min", run_len[6] >= int'(HMG), 1);

      // Pedestrian pulse with no vehicle: farm green at minimum, walk lamp on.
      do_reset(1'b0);
      repeat (19) drive(1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b1, 1'b0);
      wait_state("ped_reach_farm", 3, 30, 1'b0);
      check("ped_walk_on", bus.ped_walk, 1);
      n = 0;
      while (bus.state_o == 3'd3 && n < 30) begin drive(1'b0, 1'b0, 1'b0); n++; end
      check("ped_farm_len", n, FMIN);
      check("ped_walk_off", bus.ped_walk, 0);

      // Flash entered from farm green, then exit through RED_B.
      do_reset(1'b1);
      wait_state("flash_reach_farm", 3, 40, 1'b1);
      drive(1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         #1;
         check("flash_hwy", bus.light_highway, ((i / int'(FH)) % 2 == 0) ? 3'b010 : 3'b000);
         check("flash_farm", bus.light_farm, ((i / int'(FH)) % 2 == 0) ? 3'b100 : 3'b000);
      end
      bus.flash_en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         check("flash_exit", bus.state_o, (i < int'(ART)) ? 5 : 0);
      end

      // Asynchronous reset in FARM_Y with a pedestrian request pending.
      do_reset(1'b1);
      wait_state("rst_reach_farm_y", 4, 60, 1'b1);
      drive(1'b1, 1'b1, 1'b0);
      @(posedge clk);
      #2;
      bus.ped_req = 1'b0;
      rst_n = 1'b0;
      model_reset();
      #1;
      check("async_rst_hwy", bus.light_highway, 3'b001);
      check("async_rst_farm", bus.light_farm, 3'b100);
      check("async_rst_state", bus.state_o, 0);
      check("async_rst_walk", bus.ped_walk, 0);
      @(negedge clk);
      #1;
      bus.sensor = 1'b0;
      rst_n = 1'b1;
      repeat (40) drive(1'b0, 1'b0, 1'b0);
      check("rst_pend_cleared", bus.state_o, 0);

      // Randomised traffic checked cycle by cycle against the model.
      do_reset(1'b0);
      s_run = 0; s_val = 0; f_run = 0;
      for (int c = 0; c < 4000; c++) begin
         if (s_run == 0) begin
            s_val = $urandom_range(0, 1);
            s_run = ($urandom_range(0, 3) == 0) ? 1 : $urandom_range(2, 25);
         end
         s_run--;
         if (f_run > 0) f_run--;
         else if ($urandom_range(0, 299) == 0) f_run = $urandom_range(3, 20);
         drive(s_val[0], ($urandom_range(0, 24) == 0), (f_run > 0));
      end
      drive(1'b0, 1'b0, 1'b0);
      @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
